pipelined_addsub: RTL and testbench

- Parametrised successor to the combinational 32-bit adder.
- Computes A+B or A−B across a configurable number of register stages, splitting the operand into equal carry-chained slices.
- Valid/ready handshake on both sides, with full-pipeline stall on backpressure.
- Outputs carry, signed-overflow and zero flags; it is the arithmetic core for the multi-cycle datapath and address-generation path.

---
 rtl/pipelined_addsub_if.sv | 36 +++
 rtl/pipelined_addsub.sv | 130 +++++++++++++
 tb/tb_pipelined_addsub.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_addsub_if.sv
//------------------------------------------------------------------------------
// pipelined_addsub_if
// Operand/result handshake bundle for the pipelined adder/subtractor.
// slave modport is the arithmetic core; master modport is the producer and
// consumer side that drives operands and accepts results.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface pipelined_addsub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] val_1;
  logic [WIDTH-1:0] val_2;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  modport slave (
    input  in_valid, val_1, val_2, sub, out_ready,
    output in_ready, out_valid, out, carry_out, overflow, zero
  );

  modport master (
    output in_valid, val_1, val_2, sub, out_ready,
    input  in_ready, out_valid, out, carry_out, overflow, zero
  );
endinterface

`default_nettype wire

// File: rtl/pipelined_addsub.sv
//------------------------------------------------------------------------------
// pipelined_addsub
// A +/- B split into STAGES equal carry-chained slices, one slice per register
// stage. Upper operand slices ride forward with the data; finished lower
// result slices ride along too, so every slice leaves the last stage aligned.
// Whole-pipeline stall when the result is held by the consumer.
// Optional build macro: PIPELINED_ADDSUB_SATURATE_EN clamps the result to the
// signed limit on two's-complement overflow.
// WIDTH must be divisible by STAGES.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  pipelined_addsub_if.slave     bus
);

  localparam int c_SW   = WIDTH / STAGES;
  localparam int c_LAST = STAGES - 1;
  localparam int c_MSB  = WIDTH - 1;

  logic             w_adv;
  logic [WIDTH-1:0] w_bp;

  // The whole pipe moves only when the output slot is empty or being drained.
  assign w_adv        = !g_stage[c_LAST].r_vld || bus.out_ready;
  assign bus.in_ready = w_adv;

  // Subtraction is A + ~B + 1; the +1 enters as the slice-0 carry-in.
  assign w_bp = bus.sub ? ~bus.val_2 : bus.val_2;

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic             r_vld;
      logic             r_c;
      logic [WIDTH-1:0] r_a;
      logic [WIDTH-1:0] r_b;
      logic [WIDTH-1:0] r_sum;

      logic             w_vin;
      logic             w_cin;
      logic [WIDTH-1:0] w_ain;
      logic [WIDTH-1:0] w_bin;
      logic [WIDTH-1:0] w_sin;
      logic [WIDTH-1:0] w_snx;
      logic [c_SW:0]    w_slice;

      if (k == 0) begin : g_first
        assign w_vin = bus.in_valid;
        assign w_ain = bus.val_1;
        assign w_bin = w_bp;
        assign w_cin = bus.sub;
        assign w_sin = '0;
      end else begin : g_rest
        assign w_vin = g_stage[k-1].r_vld;
        assign w_ain = g_stage[k-1].r_a;
        assign w_bin = g_stage[k-1].r_b;
        assign w_cin = g_stage[k-1].r_c;
        assign w_sin = g_stage[k-1].r_sum;
      end

      assign w_slice = {1'b0, w_ain[k*c_SW +: c_SW]}
                     + {1'b0, w_bin[k*c_SW +: c_SW]}
                     + {{c_SW{1'b0}}, w_cin};

      // Splice this stage's slice into the partial result carried so far.
      always_comb begin
        w_snx                   = w_sin;
        w_snx[k*c_SW +: c_SW]   = w_slice[c_SW-1:0];
      end

      // Stage register: valid always shifts on advance; data loads only for a
      // real operation so bubbles leave the last result and flags untouched.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_vld <= 1'b0;
          r_c   <= 1'b0;
          r_a   <= '0;
          r_b   <= '0;
          r_sum <= '0;
        end else if (w_adv) begin
          r_vld <= w_vin;
          if (w_vin) begin
            r_c   <= w_slice[c_SW];
            r_a   <= w_ain;
            r_b   <= w_bin;
            r_sum <= w_snx;
          end
        end
      end
    end
  endgenerate

  logic [WIDTH-1:0] w_raw;
  logic [WIDTH-1:0] w_out;
  logic             w_am;
  logic             w_bm;
  logic             w_ovf;

  assign w_raw = g_stage[c_LAST].r_sum;
  assign w_am  = g_stage[c_LAST].r_a[c_MSB];
  assign w_bm  = g_stage[c_LAST].r_b[c_MSB];
  assign w_ovf = (w_am == w_bm) && (w_raw[c_MSB] != w_am);

`ifdef PIPELINED_ADDSUB_SATURATE_EN
  // Clamp toward the sign of A, which is the direction of the true result.
  always_comb begin
    w_out = w_raw;
    if (w_ovf) begin
      w_out = w_am ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign w_out = w_raw;
`endif

  assign bus.out_valid = g_stage[c_LAST].r_vld;
  assign bus.out       = w_out;
  assign bus.carry_out = g_stage[c_LAST].r_c;
  assign bus.overflow  = w_ovf;
  assign bus.zero      = (w_out == '0);

endmodule

`default_nettype wire

// File: tb/tb_pipelined_addsub.sv
//------------------------------------------------------------------------------
// tb_pipelined_addsub
// Self-checking bench: directed literal cases plus randomized traffic against
// a behavioural model of the adder and its stall/bubble rules.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipelined_addsub;

  localparam int W = 32;
  localparam int S = 4;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         o;
    logic         z;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  logic [W-1:0] got_q[$];

  pipelined_addsub_if #(.WIDTH(W)) bus ();

  pipelined_addsub #(.WIDTH(W), .STAGES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference arithmetic straight from the definition: A + B' + cin.
  function automatic res_t calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic s);
    res_t         x;
    logic [W-1:0] bp;
    logic [W:0]   t;
    bp  = s ? ~b : b;
    t   = {1'b0, a} + {1'b0, bp} + {{W{1'b0}}, s};
    x.r = t[W-1:0];
    x.c = t[W];
    x.o = (a[W-1] == bp[W-1]) && (t[W-1] != a[W-1]);
`ifdef PIPELINED_ADDSUB_SATURATE_EN
    if (x.o) x.r = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    x.z = (x.r == '0);
    return x;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting for DUT at %0t", name, $time);
  endtask

  // Behavioural model: S slots that shift together when the output slot is
  // free or drained; last holds whatever most recently reached the output.
  logic mvld[S];
  res_t mdat[S];
  res_t mlast;

  initial begin
    for (int k = 0; k < S; k++) mvld[k] = 1'b0;
    forever begin
      @(posedge clk);
      if (bus.out_valid && bus.out_ready && rst_n) got_q.push_back(bus.out);
      if (!rst_n) begin
        for (int k = 0; k < S; k++) mvld[k] = 1'b0;
        mlast = '{r: '0, c: 1'b0, o: 1'b0, z: 1'b1};
      end else if (!mvld[S-1] || bus.out_ready) begin
        for (int k = S-1; k > 0; k--) begin
          mvld[k] = mvld[k-1];
          mdat[k] = mdat[k-1];
        end
        mvld[0] = bus.in_valid;
        if (bus.in_valid) mdat[0] = calc(bus.val_1, bus.val_2, bus.sub);
        if (mvld[S-1]) mlast = mdat[S-1];
      end
      #1;
      if (chk_en) begin
        check("mdl_out_valid", {31'b0, bus.out_valid}, {31'b0, mvld[S-1]});
        check("mdl_in_ready", {31'b0, bus.in_ready},
              {31'b0, (!mvld[S-1] || bus.out_ready)});
        check("mdl_out", bus.out, mlast.r);
        check("mdl_carry", {31'b0, bus.carry_out}, {31'b0, mlast.c});
        check("mdl_ovf", {31'b0, bus.overflow}, {31'b0, mlast.o});
        check("mdl_zero", {31'b0, bus.zero}, {31'b0, mlast.z});
      end
    end
  end

  // Single operation with a bubble behind it; checks the result literally.
  task automatic do_op(input string name, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic s,
                       input logic [W-1:0] er, input logic ec,
                       input logic eo, input logic ez);
    bit seen;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.val_1 = a; bus.val_2 = b; bus.sub = s;
    @(negedge clk);
    bus.in_valid = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (bus.out_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) timeout(name);
    else begin
      check({name, "_out"}, bus.out, er);
      check({name, "_c"}, {31'b0, bus.carry_out}, {31'b0, ec});
      check({name, "_o"}, {31'b0, bus.overflow}, {31'b0, eo});
      check({name, "_z"}, {31'b0, bus.zero}, {31'b0, ez});
    end
  endtask

  initial begin
    bit seen;
    logic [W-1:0] e;
    bus.in_valid = 1'b0; bus.val_1 = '0; bus.val_2 = '0; bus.sub = 1'b0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_out", bus.out, 32'd0);
    check("rst_zero", {31'b0, bus.zero}, 32'd1);
    check("rst_carry", {31'b0, bus.carry_out}, 32'd0);
    check("rst_ovf", {31'b0, bus.overflow}, 32'd0);
    check("rst_ready", {31'b0, bus.in_ready}, 32'd1);
    chk_en = 1'b1;

    // Latency: accept at edge n, result visible after edge n+3.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.val_1 = 32'd5; bus.val_2 = 32'd9; bus.sub = 1'b0;
    @(negedge clk);
    bus.val_1 = 32'h11; bus.val_2 = 32'h22;
    check("lat_v1", {31'b0, bus.out_valid}, 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("lat_v2", {31'b0, bus.out_valid}, 32'd0);
    @(negedge clk);
    check("lat_v3", {31'b0, bus.out_valid}, 32'd0);
    @(negedge clk);
    check("lat_v4", {31'b0, bus.out_valid}, 32'd1);
    check("lat_out14", bus.out, 32'd14);
    check("lat_c", {31'b0, bus.carry_out}, 32'd0);
    check("lat_o", {31'b0, bus.overflow}, 32'd0);
    check("lat_z", {31'b0, bus.zero}, 32'd0);
    @(negedge clk);
    check("lat_v5", {31'b0, bus.out_valid}, 32'd1);
    check("lat_out33", bus.out, 32'h33);
    repeat (2) @(negedge clk);

    do_op("wrap", 32'hFFFFFFFF, 32'd1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
`ifdef PIPELINED_ADDSUB_SATURATE_EN
    do_op("povf", 32'h7FFFFFFF, 32'd1, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);
    do_op("novf", 32'h80000000, 32'd1, 1'b1, 32'h80000000, 1'b1, 1'b1, 1'b0);
`else
    do_op("povf", 32'h7FFFFFFF, 32'd1, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
    do_op("novf", 32'h80000000, 32'd1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
`endif
    do_op("sub5m9", 32'd5, 32'd9, 1'b1, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b0);
    do_op("sub9m5", 32'd9, 32'd5, 1'b1, 32'd4, 1'b1, 1'b0, 1'b0);
    do_op("subz", 32'h12345678, 32'd0, 1'b1, 32'h12345678, 1'b1, 1'b0, 1'b0);
    do_op("slice", 32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0, 1'b0, 1'b0);

    // Backpressure: four ops, stall the consumer 3 cycles once results start.
    repeat (3) @(negedge clk);
    got_q.delete();
    fork
      begin
        int i;
        i = 1;
        while (i <= 4) begin
          bus.in_valid = 1'b1; bus.val_1 = i; bus.val_2 = i + 1; bus.sub = 1'b0;
          @(posedge clk);
          if (bus.in_ready) i++;
          @(negedge clk);
        end
        bus.in_valid = 1'b0;
      end
      begin
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
          @(negedge clk);
          if (bus.out_valid) begin
            seen = 1'b1;
            break;
          end
        end
        if (!seen) timeout("bp_start");
        bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
          if (c > 0) @(negedge clk);
          #1;
          check("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
          check("bp_hold", bus.out, 32'd3);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
      end
    join
    for (int t = 0; t < 30 && got_q.size() < 4; t++) @(negedge clk);
    repeat (5) @(negedge clk);
    check("bp_count", got_q.size(), 32'd4);
    for (int k = 0; k < 4; k++) begin
      e = 3 + 2 * k;
      if (got_q.size() > 0) check("bp_order", got_q.pop_front(), e);
      else timeout("bp_order");
    end

    // Reset with two ops in flight: nothing from them may emerge.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.val_1 = 32'd100; bus.val_2 = 32'd1; bus.sub = 1'b0;
    @(negedge clk);
    bus.val_1 = 32'd200;
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mr_valid", {31'b0, bus.out_valid}, 32'd0);
    check("mr_out", bus.out, 32'd0);
    check("mr_zero", {31'b0, bus.zero}, 32'd1);
    check("mr_ready", {31'b0, bus.in_ready}, 32'd1);
    got_q.delete();
    repeat (8) @(negedge clk);
    check("mr_no_ghost", got_q.size(), 32'd0);
    do_op("mr_new", 32'd2, 32'd3, 1'b0, 32'd5, 1'b0, 1'b0, 1'b0);

    // Randomized traffic with random backpressure and bubbles.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.sub       = $urandom_range(0, 1);
      case ($urandom_range(0, 5))
        0: bus.val_1 = 32'h7FFFFFFF;
        1: bus.val_1 = 32'h80000000;
        2: bus.val_1 = 32'hFFFFFFFF;
        default: bus.val_1 = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: bus.val_2 = 32'd0;
        1: bus.val_2 = bus.val_1;
        2: bus.val_2 = 32'd1;
        default: bus.val_2 = $urandom;
      endcase
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
